// File: rtl/ibex_csr_arb_pkg.sv
`default_nettype none
// =====================================================================
// ibex_csr_arb_pkg : operation and FSM types for the CSR access arbiter
// Rev 1.0
// =====================================================================
package ibex_csr_arb_pkg;

  localparam logic [1:0] c_OP_READ  = 2'b00;
  localparam logic [1:0] c_OP_WRITE = 2'b01;
  localparam logic [1:0] c_OP_SET   = 2'b10;
  localparam logic [1:0] c_OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    CSR_READ  = c_OP_READ,
    CSR_WRITE = c_OP_WRITE,
    CSR_SET   = c_OP_SET,
    CSR_CLEAR = c_OP_CLEAR
  } csr_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_EXEC = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_csr_arb_if.sv
`default_nettype none
// =====================================================================
// ibex_csr_arb_if : request/response bundle of the CSR access arbiter
// Rev 1.0
// =====================================================================
interface ibex_csr_arb_if
  import ibex_csr_arb_pkg::*;
#(
  parameter int unsigned AddrW = 2,
  parameter int unsigned Width = 32
);
  logic [1:0]            req_valid_i;
  logic [1:0]            req_ready_o;
  logic [1:0][1:0]       req_op_i;
  logic [1:0][AddrW-1:0] req_addr_i;
  logic [1:0][Width-1:0] req_wdata_i;
  logic [1:0]            rsp_valid_o;
  logic [Width-1:0]      rsp_rdata_o;
  logic                  rsp_error_o;
  logic                  alert_o;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, alert_o, busy_o
  );

  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, alert_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/ibex_csr_arb_rr.sv
`default_nettype none
// =====================================================================
// ibex_csr_arb_rr : 2-way round-robin arbiter with a single pointer bit
// Rev 1.0
// =====================================================================
module ibex_csr_arb_rr
  import ibex_csr_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // prio_q = 1 means requester 1 wins a tie
  logic prio_q;

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = onehot2(prio_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else if (advance_i && (|grant_o)) begin
      prio_q <= grant_o[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ibex_csr_access_arb.sv
`default_nettype none
// =====================================================================
// ibex_csr_access_arb : two-requester atomic RMW access to shadowed CSRs
// Rev 1.0
// =====================================================================
module ibex_csr_access_arb
  import ibex_csr_arb_pkg::*;
#(
  parameter int unsigned      NumCsr     = 4,
  parameter int unsigned      Width      = 32,
  parameter bit               ShadowCopy = 1'b1,
  parameter logic [Width-1:0] ResetValue = '0,
  parameter int unsigned      AddrW      = (NumCsr > 1) ? $clog2(NumCsr) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ibex_csr_arb_if.slave bus
);

  arb_state_e       state_q;
  logic             gnt_q;
  logic [1:0]       op_q;
  logic [AddrW-1:0] addr_q;
  logic [Width-1:0] wdata_q;
  logic [1:0]       rsp_valid_q;
  logic [Width-1:0] rsp_rdata_q;
  logic             rsp_error_q;
  logic             alert_q;
  logic             busy_q;

  logic [1:0]        w_grant;
  logic              w_accept;
  logic [Width-1:0]  w_prim [NumCsr];
  logic [NumCsr-1:0] w_shadow_ok;
  logic [Width-1:0]  w_old;
  logic              w_old_ok;
  logic [Width-1:0]  w_new;
  logic              w_in_range;
  logic              w_integ_err;
  logic              w_mask_zero;
  logic              w_we;

  // No grant while reset is held so a reset cycle never consumes a request
  assign w_accept = (state_q == ARB_IDLE) && !rst_i && (|bus.req_valid_i);

  ibex_csr_arb_rr u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (bus.req_valid_i),
    .advance_i (w_accept),
    .grant_o   (w_grant)
  );

  assign bus.req_ready_o = w_accept ? w_grant : 2'b00;

  assign w_in_range = (32'(addr_q) < NumCsr);

  always_comb begin
    w_old    = '0;
    w_old_ok = 1'b1;
    for (int i = 0; i < NumCsr; i++) begin
      if (w_in_range && (addr_q == AddrW'(i))) begin
        w_old    = w_prim[i];
        w_old_ok = w_shadow_ok[i];
      end
    end
  end

  assign w_integ_err = ShadowCopy && w_in_range && !w_old_ok;

  always_comb begin
    case (op_q)
      c_OP_WRITE: w_new = wdata_q;
      c_OP_SET:   w_new = w_old | wdata_q;
      c_OP_CLEAR: w_new = w_old & ~wdata_q;
      default:    w_new = w_old;
    endcase
  end

  // A set/clear with an empty mask degenerates into a read
  assign w_mask_zero = ((op_q == c_OP_SET) || (op_q == c_OP_CLEAR)) && (wdata_q == '0);

  assign w_we = (state_q == ARB_EXEC) && (op_q != c_OP_READ) && w_in_range
             && !w_integ_err && !w_mask_zero;

  for (genvar i = 0; i < NumCsr; i++) begin : g_csr
    logic [Width-1:0] primary_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        primary_q <= ResetValue;
      end else if (w_we && (addr_q == AddrW'(i))) begin
        primary_q <= w_new;
      end
    end

    assign w_prim[i] = primary_q;

    if (ShadowCopy) begin : g_shadow
      logic [Width-1:0] shadow_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          shadow_q <= ~ResetValue;
        end else if (w_we && (addr_q == AddrW'(i))) begin
          shadow_q <= ~w_new;
        end
      end

      assign w_shadow_ok[i] = (primary_q == ~shadow_q);
    end else begin : g_no_shadow
      assign w_shadow_ok[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= 1'b0;
      op_q        <= c_OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      alert_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (w_accept) begin
            gnt_q   <= w_grant[1];
            op_q    <= bus.req_op_i[w_grant[1]];
            addr_q  <= bus.req_addr_i[w_grant[1]];
            wdata_q <= bus.req_wdata_i[w_grant[1]];
            busy_q  <= 1'b1;
            state_q <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          rsp_valid_q <= onehot2(gnt_q);
          rsp_rdata_q <= w_old;
          rsp_error_q <= !w_in_range || w_integ_err;
          if (w_integ_err) begin
            alert_q <= 1'b1;
          end
          state_q <= ARB_RESP;
        end
        ARB_RESP: begin
          rsp_valid_q <= 2'b00;
          rsp_rdata_q <= '0;
          rsp_error_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ARB_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_error_o = rsp_error_q;
  assign bus.alert_o     = alert_q;
  assign bus.busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ibex_csr_access_arb.sv
`default_nettype none
// =====================================================================
// tb_ibex_csr_access_arb : directed accesses checked against a cycle model
// Rev 1.0
// =====================================================================
module tb_ibex_csr_access_arb;
  import ibex_csr_arb_pkg::*;

  localparam int unsigned NCSR = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned AW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_csr_arb_if #(.AddrW(AW), .Width(W)) bus ();

  ibex_csr_access_arb #(
    .NumCsr(NCSR), .Width(W), .ShadowCopy(1'b1), .ResetValue(32'h0), .AddrW(AW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Spec-level model: memory image, corruption flags and a response timeline
  logic [31:0] m_mem [NCSR];
  bit          m_corrupt [NCSR];
  bit          m_alert;
  int          m_favour;
  int          m_exec_cyc = -1;
  int          m_resp_cyc = -1;
  int          m_free_cyc = 0;
  int          m_g, m_resp_g;
  logic [1:0]  m_op;
  logic [2:0]  m_addr;
  logic [31:0] m_wd;
  logic [31:0] m_rsp_rdata;
  bit          m_rsp_err;
  bit          chk_en = 1'b0;

  always @(negedge clk) begin
    int          g;
    logic [1:0]  e_ready, e_valid;
    logic [31:0] e_rdata;
    logic        e_err;
    bit          inr, ie, wr;
    logic [31:0] old, nv;

    g = -1;
    if (!rst && (cyc >= m_free_cyc) && (bus.req_valid_i != 2'b00)) begin
      if (bus.req_valid_i == 2'b11) g = m_favour;
      else                          g = bus.req_valid_i[1] ? 1 : 0;
    end
    e_ready = (g < 0) ? 2'b00 : (2'b01 << g);
    e_valid = 2'b00;
    e_rdata = '0;
    e_err   = 1'b0;
    if (cyc == m_resp_cyc) begin
      e_valid = 2'b01 << m_resp_g;
      e_rdata = m_rsp_rdata;
      e_err   = m_rsp_err;
    end

    if (chk_en) begin
      check("ready", {30'd0, bus.req_ready_o}, {30'd0, e_ready});
      check("rsp_valid", {30'd0, bus.rsp_valid_o}, {30'd0, e_valid});
      check("rsp_rdata", bus.rsp_rdata_o, e_rdata);
      check("rsp_error", {31'd0, bus.rsp_error_o}, {31'd0, e_err});
      check("busy", {31'd0, bus.busy_o},
            {31'd0, ((cyc == m_exec_cyc) || (cyc == m_resp_cyc))});
      check("alert", {31'd0, bus.alert_o}, {31'd0, m_alert});
    end

    if (rst) begin
      for (int i = 0; i < NCSR; i++) begin
        m_mem[i]     = 32'h0;
        m_corrupt[i] = 1'b0;
      end
      m_alert    = 1'b0;
      m_favour   = 0;
      m_exec_cyc = -1;
      m_resp_cyc = -1;
      m_free_cyc = 0;
      chk_en     = 1'b1;
    end else begin
      if (cyc == m_exec_cyc) begin
        inr = (m_addr < NCSR);
        old = inr ? m_mem[m_addr[1:0]] : 32'h0;
        ie  = inr && m_corrupt[m_addr[1:0]];
        case (m_op)
          c_OP_WRITE: nv = m_wd;
          c_OP_SET:   nv = old | m_wd;
          c_OP_CLEAR: nv = old & ~m_wd;
          default:    nv = old;
        endcase
        wr = (m_op != c_OP_READ) && inr && !ie
          && !(((m_op == c_OP_SET) || (m_op == c_OP_CLEAR)) && (m_wd == 32'h0));
        if (wr) m_mem[m_addr[1:0]] = nv;
        if (ie) m_alert = 1'b1;
        m_rsp_rdata = old;
        m_rsp_err   = !inr || ie;
        m_resp_g    = m_g;
        m_resp_cyc  = cyc + 1;
      end
      if (g >= 0) begin
        m_g        = g;
        m_op       = bus.req_op_i[g];
        m_addr     = bus.req_addr_i[g];
        m_wd       = bus.req_wdata_i[g];
        m_exec_cyc = cyc + 1;
        m_free_cyc = cyc + 3;
        m_favour   = 1 - g;
      end
    end
  end

  task automatic access(input int r, input logic [1:0] op, input logic [2:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int t0;
    bit got;
    rd  = '0;
    er  = 1'b0;
    lat = -1;
    @(posedge clk); #1;
    bus.req_valid_i[r] = 1'b1;
    bus.req_op_i[r]    = op;
    bus.req_addr_i[r]  = a;
    bus.req_wdata_i[r] = wd;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready_o[r]) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: req%0d got no ready, required ready within 20 cycles", r);
      bus.req_valid_i[r] = 1'b0;
      return;
    end
    t0 = cyc;
    @(posedge clk); #1;
    bus.req_valid_i[r] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_o[r]) begin
        got = 1'b1;
        rd  = bus.rsp_rdata_o;
        er  = bus.rsp_error_o;
        lat = cyc - t0;
      end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout: req%0d got no response, required one within 10 cycles", r);
    end
  endtask

  task automatic do_chk(input string name, input int r, input logic [1:0] op,
                        input logic [2:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(r, op, a, wd, rd, er, lat);
    check({name, "_lat"}, lat, 32'd2);
    check({name, "_rdata"}, rd, exp_rd);
    check({name, "_err"}, {31'd0, er}, {31'd0, exp_er});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int         ng, npulse;
    int         gr [4];
    int         gc [4];
    bit         got1;
    logic [31:0] r1data;

    bus.req_valid_i = '0;
    bus.req_op_i    = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_alert", {31'd0, bus.alert_o}, 32'd0);
    check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
    check("reset_rsp_valid", {30'd0, bus.rsp_valid_o}, 32'd0);

    do_chk("rd_a2", 0, c_OP_READ, 3'd2, 32'h0, 32'h0, 1'b0);

    do_chk("wr_a1", 0, c_OP_WRITE, 3'd1, 32'hA5A5_0000, 32'h0000_0000, 1'b0);
    do_chk("set_a1", 1, c_OP_SET, 3'd1, 32'h0000_00FF, 32'hA5A5_0000, 1'b0);
    do_chk("clr_a1", 0, c_OP_CLEAR, 3'd1, 32'hA000_0000, 32'hA5A5_00FF, 1'b0);
    do_chk("rd_a1", 1, c_OP_READ, 3'd1, 32'h0, 32'h05A5_00FF, 1'b0);

    do_chk("wr_a3", 0, c_OP_WRITE, 3'd3, 32'h1234_5678, 32'h0, 1'b0);
    do_chk("set0_a3", 0, c_OP_SET, 3'd3, 32'h0, 32'h1234_5678, 1'b0);
    do_chk("clr0_a3", 1, c_OP_CLEAR, 3'd3, 32'h0, 32'h1234_5678, 1'b0);
    do_chk("rd_a3", 0, c_OP_READ, 3'd3, 32'h0, 32'h1234_5678, 1'b0);
    do_chk("oor_a5", 1, c_OP_WRITE, 3'd5, 32'hDEAD_BEEF, 32'h0, 1'b1);
    check("oor_alert", {31'd0, bus.alert_o}, 32'd0);
    do_chk("rd_a1_after_oor", 0, c_OP_READ, 3'd1, 32'h0, 32'h05A5_00FF, 1'b0);

    // Arbitration with both requesters held valid
    do_reset();
    @(posedge clk); #1;
    bus.req_op_i[0]    = c_OP_WRITE;
    bus.req_addr_i[0]  = 3'd0;
    bus.req_wdata_i[0] = 32'hCAFE_0001;
    bus.req_op_i[1]    = c_OP_READ;
    bus.req_addr_i[1]  = 3'd0;
    bus.req_wdata_i[1] = 32'h0;
    bus.req_valid_i    = 2'b11;
    ng = 0; got1 = 1'b0; r1data = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.req_ready_o != 2'b00) begin
        if (ng < 4) begin
          gr[ng] = bus.req_ready_o[1] ? 1 : 0;
          gc[ng] = cyc;
        end
        ng++;
      end
      if (bus.rsp_valid_o[1] && !got1) begin
        got1   = 1'b1;
        r1data = bus.rsp_rdata_o;
      end
    end
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
    check("arb_grant_count", ng, 32'd4);
    for (int i = 0; i < 4 && i < ng; i++) begin
      check("arb_grant_order", gr[i], i % 2);
      check("arb_grant_spacing", gc[i] - gc[0], 3 * i);
    end
    check("arb_req1_rsp_seen", {31'd0, got1}, 32'd1);
    check("arb_req1_rdata", r1data, 32'hCAFE_0001);
    repeat (3) @(posedge clk);

    // Shadow corruption and sticky alert
    do_reset();
    do_chk("wr_a0", 0, c_OP_WRITE, 3'd0, 32'h0000_00F0, 32'h0, 1'b0);
    force dut.g_csr[0].g_shadow.shadow_q = 32'hFFFF_FF0E;
    m_corrupt[0] = 1'b1;
    do_chk("integ_wr_a0", 0, c_OP_WRITE, 3'd0, 32'h1111_1111, 32'h0000_00F0, 1'b1);
    release dut.g_csr[0].g_shadow.shadow_q;
    check("integ_alert_set", {31'd0, bus.alert_o}, 32'd1);
    do_chk("clean_rd_a2", 1, c_OP_READ, 3'd2, 32'h0, 32'h0, 1'b0);
    do_chk("clean_wr_a1", 0, c_OP_WRITE, 3'd1, 32'h0000_1234, 32'h0, 1'b0);
    check("integ_alert_sticky", {31'd0, bus.alert_o}, 32'd1);
    do_reset();
    @(negedge clk);
    check("alert_cleared", {31'd0, bus.alert_o}, 32'd0);
    do_chk("rd_a0_after_rst", 0, c_OP_READ, 3'd0, 32'h0, 32'h0, 1'b0);

    // Reset during EXEC of a write aborts it
    do_chk("pre_wr_a1", 0, c_OP_WRITE, 3'd1, 32'h0000_1234, 32'h0, 1'b0);
    @(posedge clk); #1;
    bus.req_op_i[0]    = c_OP_WRITE;
    bus.req_addr_i[0]  = 3'd1;
    bus.req_wdata_i[0] = 32'hFFFF_FFFF;
    bus.req_valid_i[0] = 1'b1;
    got1 = 1'b0;
    for (int k = 0; k < 10 && !got1; k++) begin
      @(negedge clk);
      if (bus.req_ready_o[0]) got1 = 1'b1;
    end
    check("abort_accepted", {31'd0, got1}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid_i[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    npulse = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_o != 2'b00) npulse++;
    end
    check("abort_no_rsp", npulse, 32'd0);
    do_chk("rd_a1_after_abort", 1, c_OP_READ, 3'd1, 32'h0, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at 100000, required completion earlier");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
